// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the fetch queue.
//   In-flight tag layout is {valid, pc}: valid sits in the MSB above an ADDR_WIDTH-bit pc.
//   Provides the configuration legality check and a ceil-log2 helper.
package fetch_pkg;
  localparam int TAG_VALID_W = 1;
  function automatic int fetch_log2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic bit fetch_cfg_ok(input int depth, input int lat);
    return depth >= 2 && (depth & (depth - 1)) == 0 && lat >= 1 && lat <= 4;
  endfunction
endpackage

// File: rtl/fetch_inflight_pipe.sv
// fetch_inflight_pipe: LAT-stage shift register of {valid, pc} tags for outstanding memory reads.
//   clk, rst     : clock, synchronous active-high reset
//   clr          : squash every in-flight tag at the next edge
//   in_valid/pc  : tag entering stage 0
//   tail_valid/pc: tag leaving the last stage (its data is on mem_rdata this cycle)
//   count        : number of valid tags in the pipe
module fetch_inflight_pipe
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int LAT = 1,
  parameter int CW = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH-1:0] in_pc,
  output logic                  tail_valid,
  output logic [ADDR_WIDTH-1:0] tail_pc,
  output logic [CW-1:0]         count
);
  localparam int TW = ADDR_WIDTH + TAG_VALID_W;
  logic [LAT*TW-1:0] tag_q, tag_d;
  logic [TW-1:0] tail;
  // New tags land in the lowest slot; truncation drops the retiring top slot.
  always_comb begin
    tag_d = clr ? '0 : (LAT*TW)'({tag_q, in_valid, in_pc});
    count = '0;
    for (int i = 0; i < LAT; i++) count = count + CW'(tag_q[i*TW+ADDR_WIDTH]);
  end
  always_ff @(posedge clk) begin
    if (rst) tag_q <= '0;
    else tag_q <= tag_d;
  end
  assign tail = tag_q[LAT*TW-1 -: TW];
  assign tail_valid = tail[TW-1];
  assign tail_pc = tail[ADDR_WIDTH-1:0];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage driving a loadable PC counter and buffering returned words.
//   clk, rst                   : clock, synchronous active-high reset
//   pc_in                      : current counter value
//   pc_run/pc_load/pc_load_val : counter increment, load and load value
//   redirect/redirect_addr     : taken branch/jump pulse and target; squashes all fetches
//   mem_rd/mem_addr/mem_rdata  : fixed-latency instruction memory read port
//   out_valid/out_ready        : decode handshake on the FIFO head
//   out_instr/out_pc           : head instruction and its pc (0 while empty)
//   FETCH_STATS_EN (optional)  : adds saturating stat_issued / stat_squashed counters
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_LATENCY = 1,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  output logic                  pc_run,
  output logic                  pc_load,
  output logic [ADDR_WIDTH-1:0] pc_load_val,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]           stat_issued,
  output logic [31:0]           stat_squashed
`endif
);
  localparam int PW = fetch_log2(DEPTH);
  localparam int CW = fetch_log2(DEPTH + 1) + 1;
  localparam int EW = DATA_WIDTH + ADDR_WIDTH;
  if (!fetch_cfg_ok(DEPTH, MEM_LATENCY)) begin : g_bad_cfg
    $error("fetch_queue: DEPTH must be a power of two >= 2 and MEM_LATENCY within 1..4");
  end
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d, inflight;
  logic tail_valid, issue, push, pop;
  logic [ADDR_WIDTH-1:0] tail_pc;
  fetch_inflight_pipe #(.ADDR_WIDTH(ADDR_WIDTH), .LAT(MEM_LATENCY), .CW(CW)) u_pipe (
    .clk(clk),
    .rst(rst),
    .clr(redirect),
    .in_valid(issue),
    .in_pc(pc_in),
    .tail_valid(tail_valid),
    .tail_pc(tail_pc),
    .count(inflight)
  );
  // Credits count in-flight reads as occupied, so a return always finds a free slot.
  always_comb begin
    issue = !rst && !redirect && (cnt_q + inflight) < CW'(DEPTH);
    push = tail_valid && !redirect;
    pop = out_valid && out_ready && !redirect;
    mem_d = mem_q;
    if (push) mem_d[wr_q] = {mem_rdata, tail_pc};
    wr_d = redirect ? '0 : wr_q + PW'(push);
    rd_d = redirect ? '0 : rd_q + PW'(pop);
    cnt_d = redirect ? '0 : cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
    mem_q <= mem_d;
  end
  assign out_valid = cnt_q != '0;
  assign out_instr = out_valid ? mem_q[rd_q][EW-1:ADDR_WIDTH] : '0;
  assign out_pc = out_valid ? mem_q[rd_q][ADDR_WIDTH-1:0] : '0;
  assign mem_rd = issue;
  assign mem_addr = pc_in;
  assign pc_run = issue;
  assign pc_load = redirect && !rst;
  assign pc_load_val = redirect_addr;
`ifdef FETCH_STATS_EN
  logic [31:0] issued_q, issued_d, squashed_q, squashed_d;
  logic [32:0] sq_sum;
  always_comb begin
    sq_sum = {1'b0, squashed_q} + 33'(cnt_q) + 33'(inflight);
    issued_d = issue && issued_q != '1 ? issued_q + 32'd1 : issued_q;
    squashed_d = !redirect ? squashed_q : sq_sum[32] ? '1 : sq_sum[31:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q <= '0;
      squashed_q <= '0;
    end else begin
      issued_q <= issued_d;
      squashed_q <= squashed_d;
    end
  end
  assign stat_issued = issued_q;
  assign stat_squashed = squashed_q;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int LAT = 1;
  localparam int DEPTH = 4;
  logic clk = 0;
  logic rst = 1;
  logic redirect = 0;
  logic out_ready = 0;
  logic [AW-1:0] pc_in = '0;
  logic [AW-1:0] redirect_addr = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic pc_run, pc_load, mem_rd, out_valid;
  logic [AW-1:0] pc_load_val, mem_addr, out_pc;
  logic [DW-1:0] out_instr;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_issued, stat_squashed;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rd_pulses = 0;
  logic [AW-1:0] bq[$];
  logic [AW-1:0] iq_pc[$];
  int iq_due[$];
  logic rq_v[LAT];
  logic [AW-1:0] rq_a[LAT];
  logic s_mem_rd, s_pc_run, s_pc_load, s_out_valid;
  logic [AW-1:0] s_mem_addr, s_pc_load_val, s_out_pc;
  logic exp_issue;
  longint m_issued = 0;
  longint m_squashed = 0;

  always #5 clk = ~clk;

  fetch_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .pc_in(pc_in),
    .pc_run(pc_run),
    .pc_load(pc_load),
    .pc_load_val(pc_load_val),
    .redirect(redirect),
    .redirect_addr(redirect_addr),
    .mem_rd(mem_rd),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc)
`ifdef FETCH_STATS_EN
    ,
    .stat_issued(stat_issued),
    .stat_squashed(stat_squashed)
`endif
  );

  function automatic logic [DW-1:0] memword(input logic [AW-1:0] a);
    return 32'(32'h9E3779B9 * (32'(a) + 32'd1)) ^ 32'h0000_5A00;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: check outputs at negedge, then advance model, counter and memory after posedge.
  task automatic cycle();
    @(negedge clk);
    exp_issue = !rst && !redirect && (bq.size() + iq_pc.size() < DEPTH);
    chk("mem_rd", mem_rd, exp_issue);
    chk("pc_run", pc_run, exp_issue);
    chk("pc_load", pc_load, redirect && !rst);
    if (exp_issue) chk("mem_addr", mem_addr, pc_in);
    if (pc_load) chk("pc_load_val", pc_load_val, redirect_addr);
    chk("out_valid", out_valid, bq.size() != 0);
    chk("out_pc", out_pc, bq.size() != 0 ? bq[0] : '0);
    chk("out_instr", out_instr, bq.size() != 0 ? memword(bq[0]) : '0);
`ifdef FETCH_STATS_EN
    chk("stat_issued", stat_issued, m_issued);
    chk("stat_squashed", stat_squashed, m_squashed);
`endif
    s_mem_rd = mem_rd;
    s_mem_addr = mem_addr;
    s_pc_run = pc_run;
    s_pc_load = pc_load;
    s_pc_load_val = pc_load_val;
    s_out_valid = out_valid;
    s_out_pc = out_pc;
    if (mem_rd) rd_pulses++;
    @(posedge clk);
    #1;
    if (rst) begin
      bq.delete();
      iq_pc.delete();
      iq_due.delete();
      m_issued = 0;
      m_squashed = 0;
    end else if (redirect) begin
      m_squashed += bq.size() + iq_pc.size();
      bq.delete();
      iq_pc.delete();
      iq_due.delete();
    end else begin
      if (out_ready && bq.size() != 0) void'(bq.pop_front());
      if (iq_due.size() != 0 && iq_due[0] == cyc) begin
        bq.push_back(iq_pc.pop_front());
        void'(iq_due.pop_front());
      end
      if (exp_issue) begin
        iq_pc.push_back(pc_in);
        iq_due.push_back(cyc + LAT);
        m_issued++;
      end
    end
    if (rst) pc_in = '0;
    else if (s_pc_load) pc_in = s_pc_load_val;
    else if (s_pc_run) pc_in = pc_in + 1'b1;
    for (int i = LAT - 1; i > 0; i--) begin
      rq_v[i] = rq_v[i-1];
      rq_a[i] = rq_a[i-1];
    end
    rq_v[0] = s_mem_rd;
    rq_a[0] = s_mem_addr;
    mem_rdata = rq_v[LAT-1] ? memword(rq_a[LAT-1]) : DW'($urandom());
    cyc++;
  endtask

  initial begin
    int first_rd, first_v;
    logic got;
    for (int i = 0; i < LAT; i++) begin
      rq_v[i] = 1'b0;
      rq_a[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    repeat (2) cycle();
    // free run from pc 0, decode always ready; wraps past 31
    rst = 0;
    out_ready = 1;
    first_rd = -1;
    first_v = -1;
    for (int i = 0; i < 45; i++) begin
      cycle();
      if (first_rd < 0 && s_mem_rd) first_rd = cyc;
      if (first_v < 0 && s_out_valid) first_v = cyc;
    end
    chk("first_latency", 64'(first_v - first_rd), LAT + 1);
    // decode stalled from reset: queue fills to DEPTH and the counter holds
    rst = 1;
    cycle();
    rst = 0;
    out_ready = 0;
    rd_pulses = 0;
    repeat (12) cycle();
    chk("stall_rd_pulses", rd_pulses, DEPTH);
    chk("stall_pc_in", pc_in, DEPTH);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_out_pc", out_pc, 0);
    // single pop refills exactly one slot from pc 4
    rd_pulses = 0;
    out_ready = 1;
    cycle();
    out_ready = 0;
    repeat (5) cycle();
    chk("refill_rd_pulses", rd_pulses, 1);
    chk("refill_pc_in", pc_in, DEPTH + 1);
    chk("refill_out_pc", out_pc, 1);
    // redirect with three buffered and one in flight
    out_ready = 1;
    cycle();
    out_ready = 0;
    cycle();
    redirect = 1;
    redirect_addr = 5'h10;
    cycle();
    chk("redir_pc_load", s_pc_load, 1);
    chk("redir_pc_run", s_pc_run, 0);
    chk("redir_load_val", s_pc_load_val, 5'h10);
    redirect = 0;
    cycle();
    chk("redir_flush_valid", s_out_valid, 0);
    out_ready = 1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle();
      got = s_out_valid;
    end
    chk("redir_found", got, 1);
    chk("redir_first_pc", s_out_pc, 5'h10);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      redirect = !rst && ($urandom_range(0, 19) == 0);
      redirect_addr = AW'($urandom());
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    // reset mid-stream with reads in flight
    rst = 0;
    redirect = 0;
    out_ready = 1;
    repeat (5) cycle();
    rst = 1;
    cycle();
    rst = 0;
    for (int i = 0; i < LAT + 1; i++) begin
      cycle();
      chk("post_rst_valid", s_out_valid, 0);
    end
    repeat (6) cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the loadable PC counter.
- Each cycle it samples the counter's address and issues a fixed-latency instruction-memory read.
- It drives the counter's run/load/dataIn, buffers returned words with their PC in a small FIFO, and presents them to decode over a valid/ready handshake.
- Branch/jump redirects reload the counter and squash all in-flight and buffered fetches.

Parameters:
- ADDR_WIDTH, 5: width of PC/address; matches the counter's BIT_WIDTH.
- DATA_WIDTH, 32: instruction word width.
- MEM_LATENCY, 1: cycles from mem_rd to mem_rdata valid; legal range 1..4.
- DEPTH, 4: FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- pc_in  in  ADDR_WIDTH  current counter count.
- pc_run  out  1  counter increment enable.
- pc_load  out  1  counter load enable.
- pc_load_val  out  ADDR_WIDTH  counter dataIn.
- redirect  in  1  branch/jump taken, one-cycle pulse.
- redirect_addr  in  ADDR_WIDTH  redirect target.
- mem_rd  out  1  read strobe.
- mem_addr  out  ADDR_WIDTH  read address.
- mem_rdata  in  DATA_WIDTH  read data, valid MEM_LATENCY cycles after mem_rd.
- out_valid  out  1  head entry valid.
- out_ready  in  1  decode accepts head.
- out_instr  out  DATA_WIDTH  head instruction.
- out_pc  out  ADDR_WIDTH  head PC.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - On reset: FIFO empty, in-flight pipe cleared, out_valid=0, mem_rd=0, pc_run=0, pc_load=0.
  - out_instr and out_pc are 0 while empty after reset.
  - Reset mid-operation discards all in-flight returns and buffered entries.
- Credit rule: issue allowed iff (fifo_count + inflight_count) < DEPTH. This guarantees a returning word always has space; no backpressure to memory.
- Issue cycle (allowed, redirect=0): combinationally mem_rd=1, mem_addr=pc_in, pc_run=1. The counter advances at the next clk edge. A tag {valid, pc_in} enters the in-flight shift pipe of length MEM_LATENCY.
- Return: when the pipe tail is valid, write {mem_rdata, tag.pc} into the FIFO at that edge. Minimum issue-to-out_valid latency is MEM_LATENCY+1 cycles.
- Dequeue: a head pop occurs on out_valid && out_ready. A simultaneous pop and push is allowed when full. out_valid/out_instr/out_pc are registered FIFO head outputs; there is no same-cycle bypass.
- Redirect cycle:
  - pc_load=1, pc_load_val=redirect_addr, pc_run=0, mem_rd=0.
  - All pipe valid bits and the FIFO are cleared at that edge.
  - out_valid is 0 the following cycle.
  - Redirect wins over issue, return and pop in the same cycle. An out_ready pop in that cycle is still honoured by decode; the entry is then gone.
- Stall: no credit -> mem_rd=0, pc_run=0; the counter holds.
- Wrap: PC wrap-around is owned by the counter. The block passes pc_in through unmodified; out_pc may go from max to 0.
- pc_load and pc_run are never both 1.

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined: adds outputs stat_issued [31:0] and stat_squashed [31:0].
  - stat_issued increments on each issue.
  - stat_squashed increments by (fifo_count + inflight_count) on each redirect.
  - Both saturate at all-ones and clear on rst.
- Undefined: no such ports or logic exist; behaviour is otherwise identical.

Decomposition:
- Shared package/include: fetch_pkg.
  - Tag layout {valid, pc}.
  - DEPTH/MEM_LATENCY legality checks.
  - log2 constant function.
- One sub-module: fetch_inflight_pipe.
  - MEM_LATENCY-stage valid+pc shift register with synchronous clear.
  - Outputs tail tag and inflight_count.

Test Plan:
- Reset, then free-run with out_ready=1, MEM_LATENCY=1, pc from 0 -> out_pc sequence 0,1,2,3,... beginning 2 cycles after the first mem_rd; out_instr equals the memory model word.
- out_ready=0 from start, DEPTH=4 -> exactly 4 mem_rd pulses; pc_run then 0; pc_in holds 4; out_valid=1 with out_pc=0.
- Queue full, then a single out_ready pulse -> one pop, one new issue at pc 4, occupancy returns to 4 after the return.
- redirect with redirect_addr=0x10 while 3 entries are buffered and 1 is in flight -> pc_load=1 and pc_load_val=0x10 that cycle; out_valid=0 the next cycle; the stale in-flight word is never output; the first output after is pc 0x10.
- MEM_LATENCY=3, counter wrap at max -> out_pc goes max then 0 with no gaps and no duplicates.
- rst asserted mid-stream with 2 in flight -> no out_valid from the squashed returns; outputs cleared; with FETCH_STATS_EN, counters read 0.
